// File: rtl/cpu_types_pkg.sv
// Shared CPU-side memory types: RAM handshake status, arbiter FSM states,
// and the sentinel load value returned when a request is abandoned.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } arb_state_t;

  localparam logic [31:0] BAD_LOAD = 32'hBAD1BAD1;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way round-robin selector: a lone requester wins, and on a tie the
// core that was not served last wins.
module rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       idx
);

  always_comb begin
    valid = |req;
    idx   = 1'b0;
    if (&req) idx = ~last;
    else      idx = req[1];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-core to single-RAM arbiter: grants one request at a time, replays it on
// RAM errors and forces completion with a sentinel once retries run out.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int MAX_RETRY = 3
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [1:0]             cREN,
  input  logic [1:0]             cWEN,
  input  logic [1:0][WORD_W-1:0] caddr,
  input  logic [1:0][WORD_W-1:0] cstore,
  output logic [1:0]             cwait,
  output logic [1:0][WORD_W-1:0] cload,
  output logic [1:0]             cerr,
  output logic                   memREN,
  output logic                   memWEN,
  output logic [WORD_W-1:0]      memaddr,
  output logic [WORD_W-1:0]      memstore,
  input  ramstate_t              ramstate,
  input  logic [WORD_W-1:0]      ramload
);

  localparam int CW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  arb_state_t        state;
  logic              last;
  logic              gidx;
  logic              wr_q;
  logic              drop;
  logic [CW-1:0]     retry_cnt;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] store_q;

  logic [1:0] req;
  logic       pick_valid;
  logic       pick_idx;
  logic       serving;
  logic       at_limit;
  logic       complete;
  logic       fail;
  logic       reissue;

  assign req = cREN | cWEN;

  rr_pick u_pick (
    .req   (req),
    .last  (last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // drop marks the one quiet cycle after an ERROR; the RAM status is ignored then
  always_comb begin
    serving  = (state == SERVE) && !drop;
    at_limit = (retry_cnt == CW'(MAX_RETRY));
    complete = serving && ((ramstate == ACCESS) || ((ramstate == ERROR) && at_limit));
    fail     = serving && (ramstate == ERROR) && at_limit;
    reissue  = serving && (ramstate == ERROR) && !at_limit;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      last      <= 1'b1;
      gidx      <= 1'b0;
      wr_q      <= 1'b0;
      drop      <= 1'b0;
      retry_cnt <= '0;
      addr_q    <= '0;
      store_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gidx    <= pick_idx;
            addr_q  <= caddr[pick_idx];
            store_q <= cstore[pick_idx];
            wr_q    <= cWEN[pick_idx];
            state   <= SERVE;
          end
        end
        SERVE: begin
          if (drop) begin
            drop <= 1'b0;
          end else if (complete) begin
            last      <= gidx;
            retry_cnt <= '0;
            state     <= IDLE;
          end else if (reissue) begin
            retry_cnt <= retry_cnt + 1'b1;
            drop      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // cwait is gated by nRST so a core still holding its request reads 0 in reset
  always_comb begin
    memREN   = serving && !wr_q;
    memWEN   = serving && wr_q;
    memaddr  = (state == SERVE) ? addr_q  : '0;
    memstore = (state == SERVE) ? store_q : '0;
    for (int i = 0; i < 2; i++) begin
      cwait[i] = nRST && req[i] && !(complete && (gidx == 1'(i)));
      cload[i] = '0;
      cerr[i]  = fail && (gidx == 1'(i));
      if (complete && (gidx == 1'(i)))
        cload[i] = fail ? WORD_W'(BAD_LOAD) : ramload;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a transaction-level model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int W    = 32;
  localparam int MAXR = 3;

  logic              CLK = 1'b0;
  logic              nRST;
  logic [1:0]        cREN, cWEN, cwait, cerr;
  logic [1:0][W-1:0] caddr, cstore, cload;
  logic              memREN, memWEN;
  logic [W-1:0]      memaddr, memstore, ramload;
  ramstate_t         ramstate;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.WORD_W(W), .MAX_RETRY(MAXR)) dut (
    .CLK(CLK), .nRST(nRST), .cREN(cREN), .cWEN(cWEN), .caddr(caddr),
    .cstore(cstore), .cwait(cwait), .cload(cload), .cerr(cerr),
    .memREN(memREN), .memWEN(memWEN), .memaddr(memaddr), .memstore(memstore),
    .ramstate(ramstate), .ramload(ramload)
  );

  always #5 CLK = ~CLK;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // RAM: answers each strobed cycle from a script, defaulting to ACCESS
  ramstate_t ram_script[$];
  always begin
    @(posedge CLK);
    #2;
    if (memREN || memWEN)
      ramstate = (ram_script.size() > 0) ? ram_script.pop_front() : ACCESS;
    else
      ramstate = FREE;
  end

  // Model state: the transaction in flight, its error count and whether it is resting
  bit       m_active, m_rest, m_write;
  int       m_core, m_errs, m_last;
  logic [W-1:0] m_addr, m_data;
  int       grant_log[$], done_log[$];
  int       dut_done[$], dut_done_cyc[$];
  logic [W-1:0] addr_log[$], store_log[$];
  int       rd_strobes, wr_strobes, err_pulses, cyc;
  bit       prev_on;

  bit                on, fin, bad, both;
  logic [1:0]        exp_wait, exp_err;
  logic [1:0][W-1:0] exp_load;
  int                w;

  always @(negedge CLK) begin
    if (!nRST) begin
      m_active = 0; m_rest = 0; m_errs = 0; m_last = 1; prev_on = 0;
      check_output("reset_ctrl", 64'({cwait, cerr, memREN, memWEN}), 64'd0);
      check_output("reset_memaddr", 64'(memaddr), 64'd0);
      check_output("reset_memstore", 64'(memstore), 64'd0);
      check_output("reset_cload", 64'(cload), 64'd0);
    end else begin
      cyc++;
      on  = m_active && !m_rest;
      fin = on && ((ramstate == ACCESS) || ((ramstate == ERROR) && (m_errs == MAXR)));
      bad = fin && (ramstate == ERROR);
      for (int i = 0; i < 2; i++) begin
        exp_wait[i] = (cREN[i] | cWEN[i]) && !(fin && m_core == i);
        exp_err[i]  = bad && (m_core == i);
        exp_load[i] = (fin && m_core == i) ? (bad ? BAD_LOAD : ramload) : '0;
      end
      check_output("strobes", 64'({memREN, memWEN}), 64'({on && !m_write, on && m_write}));
      check_output("memaddr", 64'(memaddr), 64'(m_active ? m_addr : '0));
      check_output("memstore", 64'(memstore), 64'(m_active ? m_data : '0));
      check_output("cwait", 64'(cwait), 64'(exp_wait));
      check_output("cload", 64'(cload), 64'(exp_load));
      check_output("cerr", 64'(cerr), 64'(exp_err));

      rd_strobes += int'(memREN);
      wr_strobes += int'(memWEN);
      err_pulses += int'(cerr[0]) + int'(cerr[1]);
      if ((memREN || memWEN) && !prev_on) begin
        addr_log.push_back(memaddr);
        store_log.push_back(memstore);
      end
      prev_on = memREN || memWEN;
      for (int i = 0; i < 2; i++)
        if ((cREN[i] | cWEN[i]) && !cwait[i]) begin
          dut_done.push_back(i);
          dut_done_cyc.push_back(cyc);
        end

      if (!m_active) begin
        if (|(cREN | cWEN)) begin
          both = (cREN[0] | cWEN[0]) && (cREN[1] | cWEN[1]);
          w = both ? 1 - m_last : ((cREN[1] | cWEN[1]) ? 1 : 0);
          m_active = 1; m_core = w; m_addr = caddr[w]; m_data = cstore[w];
          m_write = cWEN[w]; m_errs = 0;
          grant_log.push_back(w);
        end
      end else if (m_rest) begin
        m_rest = 0;
      end else if (fin) begin
        m_active = 0; m_last = m_core; m_errs = 0;
        done_log.push_back(m_core);
      end else if (on && ramstate == ERROR) begin
        m_errs++; m_rest = 1;
      end
    end
  end

  task automatic apply_stimulus(input logic [1:0] ren, input logic [1:0] wen,
                                input logic [W-1:0] a0, input logic [W-1:0] a1,
                                input logic [W-1:0] s0, input logic [W-1:0] s1);
    cREN = ren; cWEN = wen;
    caddr[0] = a0; caddr[1] = a1; cstore[0] = s0; cstore[1] = s1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    apply_stimulus(2'b00, 2'b00, '0, '0, '0, '0);
    ram_script.delete();
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
    grant_log.delete(); done_log.delete(); dut_done.delete(); dut_done_cyc.delete();
    addr_log.delete(); store_log.delete();
    rd_strobes = 0; wr_strobes = 0; err_pulses = 0; cyc = 0;
  endtask

  task automatic run_until_done(input int core, output int cycles,
                                output logic [W-1:0] load, output logic err);
    bit seen;
    seen = 0; cycles = 0; load = '0; err = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge CLK);
      #1;
      cycles++;
      if (!cwait[core]) begin
        seen = 1; load = cload[core]; err = cerr[core];
      end
    end
    check_output("done_seen", 64'(seen), 64'd1);
    @(posedge CLK);
    #1;
    cREN[core] = 1'b0; cWEN[core] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish");
    $fatal(1);
  end

  int           cyc_n, t0;
  logic [W-1:0] ld;
  logic         er;

  initial begin
    ramstate = FREE;
    ramload  = '0;
    cyc = 0; rd_strobes = 0; wr_strobes = 0; err_pulses = 0;

    // Core0 read behind two BUSY cycles
    do_reset();
    ramload = 32'h0000CAFE;
    ram_script = '{BUSY, BUSY, ACCESS};
    apply_stimulus(2'b01, 2'b00, 32'h40, '0, '0, '0);
    run_until_done(0, cyc_n, ld, er);
    check_output("read_cycles", 64'(cyc_n), 64'd4);
    check_output("read_load", 64'(ld), 64'h0000CAFE);
    check_output("read_strobes", 64'(rd_strobes), 64'd3);
    check_output("read_addr", 64'(addr_log[0]), 64'h40);

    // Simultaneous writes: core0 first, core1 after one bubble
    do_reset();
    apply_stimulus(2'b00, 2'b11, 32'h10, 32'h20, 32'h11, 32'h22);
    run_until_done(0, cyc_n, ld, er);
    check_output("wr0_cycles", 64'(cyc_n), 64'd2);
    run_until_done(1, cyc_n, ld, er);
    check_output("wr1_cycles", 64'(cyc_n), 64'd2);
    check_output("wr_addr_seq", 64'({addr_log[0], addr_log[1]}), {32'h10, 32'h20});
    check_output("wr_store_seq", 64'({store_log[0], store_log[1]}), {32'h11, 32'h22});
    check_output("wr_strobes", 64'(wr_strobes), 64'd2);
    check_output("wr_model_grants", 64'({grant_log[0][0], grant_log[1][0]}), 64'b01);

    // Both cores request continuously: strict alternation with bubbles
    do_reset();
    t0 = cyc;
    apply_stimulus(2'b11, 2'b00, 32'h100, 32'h200, '0, '0);
    for (int k = 0; k < 100 && dut_done.size() < 6; k++) @(negedge CLK);
    @(posedge CLK);
    #1;
    apply_stimulus(2'b00, 2'b00, '0, '0, '0, '0);
    check_output("alt_count", 64'(dut_done.size()), 64'd6);
    for (int k = 0; k < 6 && k < dut_done.size(); k++) begin
      check_output("alt_dut_grant", 64'(dut_done[k]), 64'(k % 2));
      check_output("alt_model_grant", 64'(grant_log[k]), 64'(k % 2));
    end
    if (dut_done_cyc.size() >= 6)
      check_output("alt_last_cycle", 64'(dut_done_cyc[5] - t0), 64'd12);

    // Four consecutive RAM errors exhaust the retries
    do_reset();
    ram_script = '{ERROR, ERROR, ERROR, ERROR};
    apply_stimulus(2'b10, 2'b00, '0, 32'h80, '0, '0);
    run_until_done(1, cyc_n, ld, er);
    repeat (2) @(posedge CLK);
    check_output("err_cycles", 64'(cyc_n), 64'd8);
    check_output("err_flag", 64'(er), 64'd1);
    check_output("err_load", 64'(ld), 64'hBAD1BAD1);
    check_output("err_strobes", 64'(rd_strobes), 64'd4);
    check_output("err_pulses", 64'(err_pulses), 64'd1);

    // Reset in the middle of a SERVE
    do_reset();
    ram_script = '{BUSY, BUSY, BUSY, BUSY, BUSY, BUSY};
    apply_stimulus(2'b01, 2'b00, 32'h44, '0, '0, '0);
    repeat (3) @(negedge CLK);
    #2;
    check_output("pre_reset_ren", 64'(memREN), 64'd1);
    nRST = 1'b0;
    #1;
    check_output("rst_cwait", 64'(cwait), 64'd0);
    check_output("rst_ren", 64'(memREN), 64'd0);
    check_output("rst_addr", 64'(memaddr), 64'd0);
    do_reset();
    ramload = 32'h1234;
    apply_stimulus(2'b10, 2'b00, '0, 32'h99, '0, '0);
    run_until_done(1, cyc_n, ld, er);
    check_output("post_rst_cycles", 64'(cyc_n), 64'd2);
    check_output("post_rst_load", 64'(ld), 64'h1234);
    check_output("post_rst_addr", 64'(addr_log[0]), 64'h99);

    // REN and WEN together: write wins
    do_reset();
    apply_stimulus(2'b01, 2'b01, 32'h55, '0, 32'h77, '0);
    run_until_done(0, cyc_n, ld, er);
    check_output("rw_wr_strobes", 64'(wr_strobes), 64'd1);
    check_output("rw_rd_strobes", 64'(rd_strobes), 64'd0);
    check_output("rw_store", 64'(store_log[0]), 64'h77);

    // Requester drops out mid-SERVE: transaction still finishes quietly
    do_reset();
    ram_script = '{BUSY, BUSY, ACCESS};
    apply_stimulus(2'b01, 2'b00, 32'h60, '0, '0, '0);
    @(posedge CLK);
    #1;
    apply_stimulus(2'b00, 2'b00, '0, '0, '0, '0);
    repeat (5) @(posedge CLK);
    #1;
    check_output("drop_strobes", 64'(rd_strobes), 64'd3);
    check_output("drop_model_done", 64'(done_log.size()), 64'd1);
    check_output("drop_dut_done", 64'(dut_done.size()), 64'd0);
    check_output("drop_idle_ren", 64'(memREN), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD_W, default 32, data/address width.
REQ-002 Parameter MAX_RETRY, default 3, RAM ERROR retries before forced completion.
REQ-003 CLK  input  1  clock; rising edge active.
REQ-004 nRST  input  1  reset, asynchronous, active-low.
REQ-005 cREN  input  2  per-core read request; index = core number.
REQ-006 cWEN  input  2  per-core write request.
REQ-007 caddr  input  2 x WORD_W  per-core word address.
REQ-008 cstore  input  2 x WORD_W  per-core write data.
REQ-009 cwait  output  2  per-core stall; low = request completes this cycle.
REQ-010 cload  output  2 x WORD_W  per-core read data, valid while that core's cwait is low.
REQ-011 cerr  output  2  one-cycle pulse: request completed by retry exhaustion.
REQ-012 memREN  output  1  RAM read strobe.
REQ-013 memWEN  output  1  RAM write strobe.
REQ-014 memaddr  output  WORD_W  RAM address.
REQ-015 memstore  output  WORD_W  RAM write data.
REQ-016 ramstate  input  ramstate_t  RAM status: FREE, BUSY, ACCESS, ERROR.
REQ-017 ramload  input  WORD_W  RAM read data.

Function
REQ-018 FSM states: IDLE, SERVE.
REQ-019 IDLE: no request -> stay; memREN = memWEN = 0; memaddr = memstore = 0.
REQ-020 IDLE with requests: grant round-robin; a single requester wins; with both requesting, the core not equal to last wins; go to SERVE next cycle.
REQ-021 Grant latches gidx, address, store data, and op (write when cWEN set, write beats read when both set).
REQ-022 SERVE: memaddr/memstore/memREN/memWEN driven from latched values, so the request reaches RAM one cycle after it is seen in IDLE.
REQ-023 SERVE with ramstate ACCESS: cwait[gidx] = 0, cload[gidx] = ramload, last <= gidx, retry counter cleared, next state IDLE.
REQ-024 SERVE with BUSY or FREE: hold all outputs and stay in SERVE.
REQ-025 SERVE with ERROR and retry count < MAX_RETRY: increment count, drop strobes for one cycle, then reissue.
REQ-026 SERVE with ERROR at count == MAX_RETRY: complete as in REQ-023 except cload = 32'hBAD1BAD1 and cerr[gidx] = 1 for one cycle.
REQ-027 cwait[i] = (cREN[i] | cWEN[i]) and not completing for core i this cycle; idle cores read cwait = 0.
REQ-028 cload[i] = 0 whenever core i is not completing.
REQ-029 A core that drops its request mid-SERVE still has its latched transaction completed, with no stale cwait/cload to any core.
REQ-030 A new request arriving in the completion cycle is not granted until the following IDLE cycle, giving one bubble cycle between transactions.
REQ-031 Back-to-back requests from both cores strictly alternate.

Reset
REQ-032 Asynchronous reset gives: state = IDLE, last = 1 (core 0 wins first tie), gidx = 0, retry count = 0, latched address/data = 0.
REQ-033 All outputs read 0 during reset.
REQ-034 Reset mid-SERVE abandons the transaction with no completion.

Structure
REQ-035 ramstate_t, the FSM state enum, and the BAD1BAD1 constant belong in cpu_types_pkg.
REQ-036 One sub-module, rr_pick: combinational two-way round-robin select from a request vector plus last.
REQ-037 All registers in a single always_ff on CLK / negedge nRST; outputs are combinational from state.

Verification
REQ-038 Core0 read 0x40, RAM returns ACCESS after 2 BUSY cycles with ramload 0xCAFE -> memREN high for 3 cycles; cwait[0] low in cycle 4 with cload[0] = 0xCAFE.
REQ-039 Both cores write the same cycle (0x10/0x11, 0x20/0x22) -> core0 served first, then core1; memaddr sequence 0x10 then 0x20.
REQ-040 Both cores request continuously for 6 transactions -> grants 0,1,0,1,0,1.
REQ-041 ramstate ERROR 4 consecutive times -> 3 reissues; on the 4th, cerr pulses and cload = 0xBAD1BAD1.
REQ-042 nRST asserted during SERVE -> all outputs 0 immediately; after release, a core1-only request is granted normally.
REQ-043 Core asserts both REN and WEN -> memWEN = 1 and memREN = 0.
